ddr3_command_responder: RTL and testbench

//  Synthesizable DDR3 device-side responder: decodes the SDR command bus driven by ddr3_memory_controller,

---
 rtl/ddr3_command_responder.sv | 176 +++++++++++++++++
 tb/tb_ddr3_command_responder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_command_responder.sv
// Device-side DDR3 stand-in: decodes the SDR command bus, tracks open banks, stores BL8 write
// bursts in an on-chip array and replays read bursts CL cycles after the READ command.
module ddr3_command_responder #(
    parameter int DQ_BITWIDTH           = 16,
    parameter int DM_BITWIDTH           = 2,
    parameter int ADDRESS_BITWIDTH      = 14,
    parameter int BANK_ADDRESS_BITWIDTH = 3,
    parameter int CL                    = 6,
    parameter int CWL                   = 5,
    parameter int MEM_COL_BITS          = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              ck_en,
    input  logic                              cs_n,
    input  logic                              ras_n,
    input  logic                              cas_n,
    input  logic                              we_n,
    input  logic [BANK_ADDRESS_BITWIDTH-1:0]  bank_address,
    input  logic [ADDRESS_BITWIDTH-1:0]       address,
    input  logic [DQ_BITWIDTH-1:0]            wdata,
    input  logic [DM_BITWIDTH-1:0]            dm,
    output logic [DQ_BITWIDTH-1:0]            rdata,
    output logic                              rvalid,
    output logic [2**BANK_ADDRESS_BITWIDTH-1:0] bank_open,
    output logic [ADDRESS_BITWIDTH-1:0]       mode_reg_0,
    output logic                              error,
    output logic [2:0]                        error_code
);
    localparam int IDX_BITS  = BANK_ADDRESS_BITWIDTH + MEM_COL_BITS;
    localparam int WORD_BITS = IDX_BITS + 3;

    typedef enum logic [2:0] {
        CMD_MRS = 3'b000, CMD_REF = 3'b001, CMD_PRE = 3'b010, CMD_ACT = 3'b011,
        CMD_WR  = 3'b100, CMD_RD  = 3'b101, CMD_ZQ  = 3'b110, CMD_NOP = 3'b111
    } cmd_t;

    logic [DQ_BITWIDTH-1:0] mem [2**WORD_BITS];

    cmd_t                 cmd;
    logic                 cmd_valid;
    logic                 bank_is_open;
    logic [IDX_BITS-1:0]  idx;
    logic [2:0]           err_c;
    logic                 wr_acc, rd_acc;
    logic [2:0]           wr_gap, rd_gap;

    logic [CWL:1]         wr_pipe;
    logic [IDX_BITS-1:0]  wr_idx_pipe [CWL:1];
    logic [CL:1]          rd_pipe;
    logic [IDX_BITS-1:0]  rd_idx_pipe [CL:1];

    logic                 wr_active, rd_active;
    logic [2:0]           wr_beat, rd_beat;
    logic [IDX_BITS-1:0]  wr_idx, rd_idx;
    logic                 wr_start, rd_start, wr_en;
    logic [WORD_BITS-1:0] wr_word, rd_word;

    assign cmd          = cmd_t'({ras_n, cas_n, we_n});
    assign cmd_valid    = ck_en & ~cs_n;
    assign bank_is_open = bank_open[bank_address];
    assign idx          = {bank_address, address[MEM_COL_BITS+2:3]};

    // Row is not part of the storage index, so only open/closed state per bank is kept.
    always_comb begin
        err_c  = 3'd0;
        wr_acc = 1'b0;
        rd_acc = 1'b0;
        if (cmd_valid) begin
            case (cmd)
                CMD_ACT: if (bank_is_open) err_c = 3'd1;
                CMD_REF: if (|bank_open) err_c = 3'd2;
                CMD_MRS: if (|bank_open) err_c = 3'd6;
                CMD_WR, CMD_RD: begin
                    if (!bank_is_open)                                     err_c = 3'd3;
                    else if (address[2:0] != 3'd0)                         err_c = 3'd4;
                    else if ((cmd == CMD_WR) ? (wr_gap != 3'd0) : (rd_gap != 3'd0)) err_c = 3'd5;
                    else begin
                        wr_acc = (cmd == CMD_WR);
                        rd_acc = (cmd == CMD_RD);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_open  <= '0;
            mode_reg_0 <= '0;
            error      <= 1'b0;
            error_code <= 3'd0;
            wr_gap     <= 3'd0;
            rd_gap     <= 3'd0;
        end else begin
            error <= (err_c != 3'd0);
            if (err_c != 3'd0) begin
                error_code <= err_c;
            end else if (cmd_valid) begin
                case (cmd)
                    CMD_ACT: bank_open[bank_address] <= 1'b1;
                    CMD_PRE: if (address[10]) bank_open <= '0;
                             else bank_open[bank_address] <= 1'b0;
                    CMD_MRS: if (bank_address == '0) mode_reg_0 <= address;
                    default: ;
                endcase
            end
            if (wr_acc) wr_gap <= 3'd7;
            else if (wr_gap != 3'd0) wr_gap <= wr_gap - 3'd1;
            if (rd_acc) rd_gap <= 3'd7;
            else if (rd_gap != 3'd0) rd_gap <= rd_gap - 3'd1;
        end
    end

    assign wr_start = wr_pipe[CWL];
    assign rd_start = rd_pipe[CL];
    assign wr_word  = wr_start ? {wr_idx_pipe[CWL], 3'd0} : {wr_idx, wr_beat};
    assign rd_word  = rd_start ? {rd_idx_pipe[CL], 3'd0} : {rd_idx, rd_beat};
    assign wr_en    = (wr_start | wr_active) & ~reset;

    // Burst indices ride alongside the valid pipes; only the valids need clearing on reset.
    always_ff @(posedge clk) begin
        wr_idx_pipe[1] <= idx;
        for (int s = 2; s <= CWL; s++) wr_idx_pipe[s] <= wr_idx_pipe[s-1];
        rd_idx_pipe[1] <= idx;
        for (int s = 2; s <= CL; s++) rd_idx_pipe[s] <= rd_idx_pipe[s-1];
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int j = 0; j < DM_BITWIDTH; j++)
                if (!dm[j]) mem[wr_word][8*j +: 8] <= wdata[8*j +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_pipe   <= '0;
            rd_pipe   <= '0;
            wr_active <= 1'b0;
            rd_active <= 1'b0;
            wr_beat   <= 3'd0;
            rd_beat   <= 3'd0;
            rvalid    <= 1'b0;
            rdata     <= '0;
        end else begin
            wr_pipe[1] <= wr_acc;
            for (int s = 2; s <= CWL; s++) wr_pipe[s] <= wr_pipe[s-1];
            rd_pipe[1] <= rd_acc;
            for (int s = 2; s <= CL; s++) rd_pipe[s] <= rd_pipe[s-1];

            if (wr_start) begin
                wr_active <= 1'b1;
                wr_beat   <= 3'd1;
                wr_idx    <= wr_idx_pipe[CWL];
            end else if (wr_active) begin
                wr_beat <= wr_beat + 3'd1;
                if (wr_beat == 3'd7) wr_active <= 1'b0;
            end

            if (rd_start) begin
                rd_active <= 1'b1;
                rd_beat   <= 3'd1;
                rd_idx    <= rd_idx_pipe[CL];
            end else if (rd_active) begin
                rd_beat <= rd_beat + 3'd1;
                if (rd_beat == 3'd7) rd_active <= 1'b0;
            end

            // Array read happens before this edge's commit lands, so a same-cycle hit sees old data.
            rvalid <= rd_start | rd_active;
            rdata  <= (rd_start | rd_active) ? mem[rd_word] : '0;
        end
    end
endmodule

// File: tb/tb_ddr3_command_responder.sv
// Directed bench for ddr3_command_responder: write/read bursts, byte masks, protocol errors,
// burst spacing, bank bookkeeping, MRS and reset in the middle of a read burst.
module tb_ddr3_command_responder;
    localparam int CL  = 6;
    localparam int CWL = 5;
    localparam logic [2:0] C_MRS = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011,
                           C_WR  = 3'b100, C_RD  = 3'b101;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ck_en = 1'b1;
    logic        cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [2:0]  bank_address = '0;
    logic [13:0] address = '0;
    logic [15:0] wdata = '0;
    logic [1:0]  dm = '0;
    logic [15:0] rdata;
    logic        rvalid;
    logic [7:0]  bank_open;
    logic [13:0] mode_reg_0;
    logic        error;
    logic [2:0]  error_code;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [15:0] exp_data [8];
    logic [15:0] wbuf [8];
    logic [1:0]  mbuf [8];
    logic        rv_log [40];
    logic [15:0] rd_log [40];
    logic        err_log [40];
    logic [2:0]  code_log [40];

    ddr3_command_responder dut (
        .clk(clk), .reset(reset), .ck_en(ck_en), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n),
        .we_n(we_n), .bank_address(bank_address), .address(address), .wdata(wdata), .dm(dm),
        .rdata(rdata), .rvalid(rvalid), .bank_open(bank_open), .mode_reg_0(mode_reg_0),
        .error(error), .error_code(error_code)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [2:0] rcw, input logic [2:0] ba, input logic [13:0] addr);
        cs_n = 1'b0;
        {ras_n, cas_n, we_n} = rcw;
        bank_address = ba;
        address = addr;
    endtask

    task automatic deselect();
        cs_n = 1'b1;
        {ras_n, cas_n, we_n} = 3'b111;
        bank_address = '0;
        address = '0;
    endtask

    task automatic issue(input logic [2:0] rcw, input logic [2:0] ba, input logic [13:0] addr);
        set_cmd(rcw, ba, addr);
        tick();
        deselect();
    endtask

    task automatic wr_burst(input logic [2:0] ba, input logic [13:0] addr);
        issue(C_WR, ba, addr);
        repeat (CWL - 1) tick();
        for (int k = 0; k < 8; k++) begin
            wdata = wbuf[k];
            dm = mbuf[k];
            tick();
        end
        wdata = '0;
        dm = '0;
    endtask

    // RD at cycle 0 and optionally a second RD at cycle second_at; outputs logged per cycle.
    task automatic capture(input int second_at, input logic [2:0] ba, input logic [13:0] addr);
        for (int c = 0; c < 40; c++) begin
            if (c == 0 || c == second_at) set_cmd(C_RD, ba, addr);
            else deselect();
            tick();
            rv_log[c] = rvalid;
            rd_log[c] = rdata;
            err_log[c] = error;
            code_log[c] = error_code;
        end
        deselect();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        total_cnt++;
        if ({rvalid, bank_open, error, error_code} !== 12'd0)
            $display("FAIL reset_ctrl: rvalid=%b bank_open=%h error=%b code=%0d expected all 0",
                     rvalid, bank_open, error, error_code);
        else pass_cnt++;
        total_cnt++;
        if (rdata !== 16'h0 || mode_reg_0 !== 14'h0)
            $display("FAIL reset_data: rdata=%h mode_reg_0=%h expected 0", rdata, mode_reg_0);
        else pass_cnt++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        issue(C_ACT, 3'd0, 14'd5);
        total_cnt++;
        if (bank_open !== 8'h01) $display("FAIL act_b0: bank_open=%h expected 01", bank_open);
        else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            wbuf[k] = 16'h1111 * 16'(k + 1);
            mbuf[k] = 2'b00;
            exp_data[k] = wbuf[k];
        end
        wr_burst(3'd0, 14'd0);
        capture(-1, 3'd0, 14'd0);
        total_cnt++;
        if (rv_log[CL-1] !== 1'b0) $display("FAIL rd_early: rvalid=%b expected 0", rv_log[CL-1]);
        else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            total_cnt++;
            if (rv_log[CL+k] !== 1'b1 || rd_log[CL+k] !== exp_data[k])
                $display("FAIL rd_beat%0d: rvalid=%b rdata=%h expected 1/%h",
                         k, rv_log[CL+k], rd_log[CL+k], exp_data[k]);
            else pass_cnt++;
        end
        total_cnt++;
        if (rv_log[CL+8] !== 1'b0) $display("FAIL rd_end: rvalid=%b expected 0", rv_log[CL+8]);
        else pass_cnt++;
    endtask

    task automatic test_dm();
        for (int k = 0; k < 8; k++) begin
            wbuf[k] = 16'hFFFF;
            mbuf[k] = 2'b11;
        end
        wbuf[2] = 16'hABCD;
        mbuf[2] = 2'b10;
        exp_data[2] = 16'h33CD;
        wr_burst(3'd0, 14'd0);
        capture(-1, 3'd0, 14'd0);
        for (int k = 0; k < 8; k++) begin
            total_cnt++;
            if (rv_log[CL+k] !== 1'b1 || rd_log[CL+k] !== exp_data[k])
                $display("FAIL dm_beat%0d: rvalid=%b rdata=%h expected 1/%h",
                         k, rv_log[CL+k], rd_log[CL+k], exp_data[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_errors();
        int nv;
        capture(-1, 3'd3, 14'd0);
        nv = 0;
        for (int c = 0; c < 40; c++) if (rv_log[c] === 1'b1) nv++;
        total_cnt++;
        if (err_log[0] !== 1'b1 || code_log[0] !== 3'd3 || nv != 0)
            $display("FAIL rd_closed: error=%b code=%0d beats=%0d expected 1/3/0",
                     err_log[0], code_log[0], nv);
        else pass_cnt++;
        total_cnt++;
        if (err_log[1] !== 1'b0 || code_log[1] !== 3'd3)
            $display("FAIL err_hold: error=%b code=%0d expected 0/3", err_log[1], code_log[1]);
        else pass_cnt++;
        issue(C_ACT, 3'd1, 14'd9);
        issue(C_REF, 3'd0, 14'd0);
        total_cnt++;
        if (error !== 1'b1 || error_code !== 3'd2 || bank_open !== 8'h03)
            $display("FAIL ref_open: error=%b code=%0d bank_open=%h expected 1/2/03",
                     error, error_code, bank_open);
        else pass_cnt++;
        issue(C_ACT, 3'd1, 14'd9);
        total_cnt++;
        if (error !== 1'b1 || error_code !== 3'd1 || bank_open !== 8'h03)
            $display("FAIL act_twice: error=%b code=%0d bank_open=%h expected 1/1/03",
                     error, error_code, bank_open);
        else pass_cnt++;
        issue(C_RD, 3'd0, 14'd5);
        total_cnt++;
        if (error !== 1'b1 || error_code !== 3'd4)
            $display("FAIL rd_unaligned: error=%b code=%0d expected 1/4", error, error_code);
        else pass_cnt++;
        issue(C_MRS, 3'd0, 14'h1234);
        total_cnt++;
        if (error !== 1'b1 || error_code !== 3'd6 || mode_reg_0 !== 14'h0)
            $display("FAIL mrs_open: error=%b code=%0d mode_reg_0=%h expected 1/6/0000",
                     error, error_code, mode_reg_0);
        else pass_cnt++;
        issue(C_PRE, 3'd1, 14'd0);
        total_cnt++;
        if (error !== 1'b0 || bank_open !== 8'h01)
            $display("FAIL pre_b1: error=%b bank_open=%h expected 0/01", error, bank_open);
        else pass_cnt++;
    endtask

    task automatic test_spacing();
        int nv;
        capture(4, 3'd0, 14'd0);
        nv = 0;
        for (int c = 0; c < 40; c++) if (rv_log[c] === 1'b1) nv++;
        total_cnt++;
        if (err_log[4] !== 1'b1 || code_log[4] !== 3'd5 || nv != 8)
            $display("FAIL rd_spacing4: error=%b code=%0d beats=%0d expected 1/5/8",
                     err_log[4], code_log[4], nv);
        else pass_cnt++;
        capture(8, 3'd0, 14'd0);
        total_cnt++;
        if (err_log[8] !== 1'b0) $display("FAIL rd_spacing8_err: error=%b expected 0", err_log[8]);
        else pass_cnt++;
        nv = 0;
        for (int c = CL; c < CL + 16; c++) if (rv_log[c] === 1'b1) nv++;
        total_cnt++;
        if (nv != 16 || rv_log[CL+16] !== 1'b0 || rv_log[CL-1] !== 1'b0)
            $display("FAIL rd_b2b_valid: contiguous=%0d after=%b before=%b expected 16/0/0",
                     nv, rv_log[CL+16], rv_log[CL-1]);
        else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            total_cnt++;
            if (rd_log[CL+8+k] !== exp_data[k])
                $display("FAIL rd_b2b_beat%0d: rdata=%h expected %h", k, rd_log[CL+8+k], exp_data[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_banks();
        issue(C_PRE, 3'd0, 14'h0400);
        total_cnt++;
        if (bank_open !== 8'h00) $display("FAIL pre_all0: bank_open=%h expected 00", bank_open);
        else pass_cnt++;
        ck_en = 1'b0;
        issue(C_ACT, 3'd2, 14'd1);
        ck_en = 1'b1;
        total_cnt++;
        if (bank_open !== 8'h00) $display("FAIL cke_low: bank_open=%h expected 00", bank_open);
        else pass_cnt++;
        for (int b = 0; b < 8; b++) issue(C_ACT, 3'(b), 14'(b + 3));
        total_cnt++;
        if (bank_open !== 8'hFF || error !== 1'b0)
            $display("FAIL act_all: bank_open=%h error=%b expected FF/0", bank_open, error);
        else pass_cnt++;
        issue(C_PRE, 3'd4, 14'h0400);
        total_cnt++;
        if (bank_open !== 8'h00) $display("FAIL pre_all: bank_open=%h expected 00", bank_open);
        else pass_cnt++;
        issue(C_PRE, 3'd5, 14'd0);
        total_cnt++;
        if (error !== 1'b0) $display("FAIL pre_closed: error=%b expected 0", error);
        else pass_cnt++;
        issue(C_MRS, 3'd0, 14'h1D70);
        total_cnt++;
        if (mode_reg_0 !== 14'h1D70 || error !== 1'b0)
            $display("FAIL mrs0: mode_reg_0=%h error=%b expected 1D70/0", mode_reg_0, error);
        else pass_cnt++;
        issue(C_MRS, 3'd2, 14'h0123);
        total_cnt++;
        if (mode_reg_0 !== 14'h1D70) $display("FAIL mrs2: mode_reg_0=%h expected 1D70", mode_reg_0);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_burst();
        int nv;
        issue(C_ACT, 3'd0, 14'd5);
        nv = 0;
        for (int c = 0; c <= CL + 2; c++) begin
            if (c == 0) set_cmd(C_RD, 3'd0, 14'd0);
            else deselect();
            tick();
            if (c >= CL && rvalid === 1'b1) nv++;
        end
        total_cnt++;
        if (nv != 3) $display("FAIL rst_pre_beats: beats=%0d expected 3", nv);
        else pass_cnt++;
        reset = 1'b1;
        tick();
        total_cnt++;
        if (rvalid !== 1'b0 || rdata !== 16'h0 || bank_open !== 8'h00 || mode_reg_0 !== 14'h0)
            $display("FAIL rst_mid: rvalid=%b rdata=%h bank_open=%h mode_reg_0=%h expected 0/0/00/0",
                     rvalid, rdata, bank_open, mode_reg_0);
        else pass_cnt++;
        reset = 1'b0;
        nv = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (rvalid !== 1'b0) nv++;
        end
        total_cnt++;
        if (nv != 0) $display("FAIL rst_no_beats: beats=%0d expected 0", nv);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_dm();
        test_errors();
        test_spacing();
        test_banks();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
